// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU, the result FIFO and the result consumer.
// master = producer/consumer side, slave = FIFO side.
interface alu_result_fifo_if #(
  parameter int unsigned SIZE  = 2,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned RW = 2 * SIZE;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_command;
  logic          in_overflow;
  logic [RW-1:0] in_result;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_command;
  logic          out_overflow;
  logic          out_zero;
  logic [RW-1:0] out_result;
  logic [CW-1:0] count;
  logic          sticky_overflow;
  logic          clear_sticky;

  modport master (
    output in_valid, in_command, in_overflow, in_result, out_ready, clear_sticky,
    input  in_ready, out_valid, out_command, out_overflow, out_zero, out_result,
           count, sticky_overflow
  );

  modport slave (
    input  in_valid, in_command, in_overflow, in_result, out_ready, clear_sticky,
    output in_ready, out_valid, out_command, out_overflow, out_zero, out_result,
           count, sticky_overflow
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO capturing ALU results with a per-entry zero flag
// and a sticky overflow status.
module alu_result_fifo #(
  parameter int unsigned SIZE  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_result_fifo_if.slave bus
);
  localparam int unsigned RW = 2 * SIZE;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [3:0]    cmd;
    logic          ovf;
    logic          zero;
    logic [RW-1:0] res;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          sticky_q, sticky_d;
  logic          full, empty, push, pop;
  entry_t        head;

  // Handshake qualifiers use registered occupancy only, so in_ready never sees out_ready.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;

  always_comb begin
    wptr_d   = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d   = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    sticky_d = sticky_q;
    if (bus.clear_sticky)           sticky_d = 1'b0;
    if (push && bus.in_overflow)    sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage is not reset; count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= '{cmd:  bus.in_command,
                         ovf:  bus.in_overflow,
                         zero: (bus.in_result == '0),
                         res:  bus.in_result};
    end
  end

  always_comb begin
    head             = mem_q[rptr_q];
    bus.in_ready     = !full;
    bus.out_valid    = !empty;
    bus.count        = count_q;
    bus.sticky_overflow = sticky_q;
    bus.out_command  = '0;
    bus.out_overflow = 1'b0;
    bus.out_zero     = 1'b0;
    bus.out_result   = '0;
    if (!empty) begin
      bus.out_command  = head.cmd;
      bus.out_overflow = head.ovf;
      bus.out_zero     = head.zero;
      bus.out_result   = head.res;
    end
  end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed sequences then random traffic.
module tb_alu_result_fifo;
  localparam int unsigned SIZE  = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = 2 * SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_fifo_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

  alu_result_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]    cmd;
    logic          ovf;
    logic [RW-1:0] res;
  } exp_t;

  exp_t model[$];
  logic sticky_m = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare, then apply the coming edge to the model.
  always @(negedge clk) begin
    int   sz;
    logic acc, pp;
    exp_t e;
    if (!rst_n) begin
      model.delete();
      sticky_m = 1'b0;
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_sticky", 32'(bus.sticky_overflow), 0);
    end else begin
      sz = model.size();
      chk("count", 32'(bus.count), 32'(sz));
      chk("in_ready", 32'(bus.in_ready), 32'(sz != DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(sz != 0));
      chk("sticky", 32'(bus.sticky_overflow), 32'(sticky_m));
      if (sz > 0) begin
        e = model[0];
        chk("out_command", 32'(bus.out_command), 32'(e.cmd));
        chk("out_overflow", 32'(bus.out_overflow), 32'(e.ovf));
        chk("out_zero", 32'(bus.out_zero), 32'(e.res == 0));
        chk("out_result", 32'(bus.out_result), 32'(e.res));
      end else begin
        chk("masked_outputs", {bus.out_command, bus.out_overflow, bus.out_zero, bus.out_result}, 0);
      end
      acc = bus.in_valid && (sz != DEPTH);
      pp  = bus.out_ready && (sz != 0);
      if (pp) void'(model.pop_front());
      if (acc) begin
        e.cmd = bus.in_command;
        e.ovf = bus.in_overflow;
        e.res = bus.in_result;
        model.push_back(e);
      end
      if (acc && bus.in_overflow) sticky_m = 1'b1;
      else if (bus.clear_sticky)  sticky_m = 1'b0;
    end
  end

  task automatic step(input logic v, input logic [3:0] cmd, input logic ovf,
                      input logic [RW-1:0] res, input logic ordy, input logic clr);
    @(posedge clk);
    #2;
    bus.in_valid     = v;
    bus.in_command   = cmd;
    bus.in_overflow  = ovf;
    bus.in_result    = res;
    bus.out_ready    = ordy;
    bus.clear_sticky = clr;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, '0, ordy, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_command = '0; bus.in_overflow = 1'b0;
    bus.in_result = '0; bus.out_ready = 1'b0; bus.clear_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single word, held until consumed
    step(1'b1, 4'd4, 1'b0, 8'h03, 1'b0, 1'b0);
    idle(1'b0, 3);
    idle(1'b1, 1);
    idle(1'b0, 2);

    // Fill, blocked fifth word, drain
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, RW'(i), 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b0, 8'd9, 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b0, 8'd9, 1'b0, 1'b0);
    idle(1'b1, 6);

    // Streaming with pointer wrap
    for (int i = 0; i < 12; i++) step(1'b1, 4'(i), 1'b0, RW'(i), 1'b1, 1'b0);
    idle(1'b1, 2);

    // Zero flag and sticky overflow
    step(1'b1, 4'd5, 1'b1, 8'h00, 1'b0, 1'b0);
    idle(1'b0, 1);
    step(1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(1'b0, 1);
    step(1'b1, 4'd6, 1'b1, 8'h80, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Full FIFO with push and pop requested together
    for (int i = 0; i < 4; i++) step(1'b1, 4'd2, 1'b0, RW'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b1, 8'h20, 1'b1, 1'b0);
    step(1'b1, 4'd3, 1'b0, 8'h21, 1'b1, 1'b0);
    idle(1'b0, 2);

    // Asynchronous reset between edges with count=3
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 0);
    chk("async_count", 32'(bus.count), 0);
    chk("async_sticky", 32'(bus.sticky_overflow), 0);
    chk("async_in_ready", 32'(bus.in_ready), 1);
    chk("async_masked", {bus.out_command, bus.out_overflow, bus.out_zero, bus.out_result}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [RW-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom);
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 7) == 0), r,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end
    idle(1'b1, DEPTH + 2);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the combinational ALU.
- Captures each ALU result (result, overflow, issuing command) into a DEPTH-entry first-word-fall-through FIFO behind a valid/ready handshake, so the consumer (writeback/display) can stall without losing results.
- Derives a per-entry zero flag and keeps a sticky overflow status for the control logic.

Parameters:
SIZE, 2, ALU operand width; result width is 2*SIZE, matching the ALU output.
DEPTH, 4, number of FIFO entries; power of two, >= 2.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ALU output word present this cycle
in_ready  output  1  FIFO can accept a word
in_command  input  4  command applied to the ALU for this word
in_overflow  input  1  ALU overflow output
in_result  input  2*SIZE  ALU result output
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_command  output  4  command of head entry
out_overflow  output  1  overflow of head entry
out_zero  output  1  head entry result == 0
out_result  output  2*SIZE  result of head entry
count  output  $clog2(DEPTH)+1  current number of stored entries
sticky_overflow  output  1  set by any accepted word with overflow=1
clear_sticky  input  1  synchronous clear of sticky_overflow

Behaviour:
- Clock/reset: one clock, clk; reset asynchronous, active-low, rst_n.
- Reset (rst_n=0, asynchronous):
  - read/write pointers and count = 0; sticky_overflow = 0; out_valid = 0.
  - in_ready = 1 (empty FIFO).
  - Storage array contents need not be reset.
- Push: in_valid && in_ready at a rising edge writes {in_command, in_overflow, (in_result==0), in_result} at the write pointer.
  - Write pointer increments modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge advances the read pointer modulo DEPTH.
- in_ready = (count != DEPTH), derived from registered state only; no combinational path from out_ready.
- out_valid = (count != 0).
- Output masking: out_command, out_overflow, out_zero and out_result show the head entry when out_valid=1 and are driven to 0 when out_valid=0.
- Latency: a word pushed into an empty FIFO appears on the outputs with out_valid=1 in the next cycle; no same-cycle bypass.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Legal whenever 0 < count < DEPTH.
  - When full, in_ready=0 so no push occurs, even if a pop happens that cycle.
  - When empty, no pop occurs.
- Count update: +1 on push only, -1 on pop only, unchanged otherwise.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0; count disambiguates full vs empty.
- Producer rule: in_valid with in_ready=0 is not an error; the word is not captured and the producer must hold it.
- Sticky overflow:
  - Set on any accepted push with in_overflow=1.
  - Cleared when clear_sticky=1.
  - If set and clear occur in the same cycle, set wins (sticky_overflow=1).
- Zero flag: computed over the full 2*SIZE-bit result at push time. The overflow bit is not included.
- Reset asserted mid-operation: all entries are discarded immediately; outputs return to their reset values asynchronously.
- No output depends combinationally on in_* inputs.

Test Plan:
- Reset, then push one word (cmd=4, ovf=0, result=8'h03, SIZE=4) with out_ready=0:
  - next cycle out_valid=1, out_result=8'h03, out_zero=0, count=1.
  - holds until out_ready=1, then out_valid=0 the following cycle.
- Fill to DEPTH=4 with results 1,2,3,4 and out_ready=0:
  - after the 4th push in_ready=0 and count=4; a 5th word (9) with in_valid held is not captured.
  - Drain with out_ready=1 yields 1,2,3,4 in order; then out_valid=0 with outputs 0.
- Continuous streaming, in_valid=1 and out_ready=1 for 12 cycles (values 0..11):
  - count stays at 1 after the first cycle.
  - outputs appear in order one cycle late; pointers wrap three times without loss.
- Push cmd=5, ovf=1, result=0:
  - out_zero=1, out_overflow=1, sticky_overflow=1.
  - clear_sticky=1 alone clears it next cycle.
  - clear_sticky=1 on the same cycle as another ovf=1 push leaves sticky_overflow=1.
- Full FIFO with out_ready=1 and in_valid=1: first cycle pops only (count 4->3); next cycle push and pop both occur (count stays 3).
- With count=3, drive rst_n=0 between clock edges: out_valid=0, count=0 and sticky_overflow=0 immediately, without waiting for a clock edge.
